// File: rtl/adc_result_reader_if.sv
// Host register port of adc_result_reader.
//   reg_wr_en / reg_rd_en : write and read strobes, one cycle each
//   reg_addr              : 3-bit register address
//   reg_wdata             : write data
//   reg_rdata             : read data, registered, valid when reg_rdata_valid=1
//   reg_rdata_valid       : high exactly one cycle after an accepted read strobe
// master = host side, slave = adc_result_reader.
interface adc_result_reader_if;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [2:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic        reg_rdata_valid;

  modport master (
    output reg_wr_en, reg_rd_en, reg_addr, reg_wdata,
    input  reg_rdata, reg_rdata_valid
  );

  modport slave (
    input  reg_wr_en, reg_rd_en, reg_addr, reg_wdata,
    output reg_rdata, reg_rdata_valid
  );
endinterface

// File: rtl/adc_result_reader.sv
// Host-side counterpart of the SAR-ADC digital core. Holds the ADC configuration
// words and the ADC reset, captures each result on the rising edge of the
// conversion-finished strobe into a FIFO, and exposes everything through a
// small register port with one cycle of read latency.
// Ports:
//   clk, rst          : single clock, synchronous active-high reset
//   bus (slave)       : host register port (see adc_result_reader_if)
//   config_1_out/2_out: configuration words to the ADC core
//   adc_rst_n_out     : ADC reset, low holds the ADC in reset (CTRL bit0)
//   result_in         : ADC conversion result
//   conv_finished_in  : ADC conversion-finished strobe
//   fifo_nempty_out   : FIFO holds at least one sample (host interrupt)
// Register map: 0 CFG1, 1 CFG2, 2 CTRL, 3 STATUS, 4 DATA (pop), 5 CNT, 6-7 zero.
module adc_result_reader #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] CFG1_RESET = 16'h0000,
  parameter logic [15:0] CFG2_RESET = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  adc_result_reader_if.slave  bus,
  output logic [15:0]         config_1_out,
  output logic [15:0]         config_2_out,
  output logic                adc_rst_n_out,
  input  logic [15:0]         result_in,
  input  logic                conv_finished_in,
  output logic                fifo_nempty_out
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [15:0]      cfg1, cfg2, cnt;
  logic             ctrl_en, conv_prev;
  logic             overflow, underflow;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic [15:0]      mem [FIFO_DEPTH];
  logic [15:0]      rdata_p1;
  logic             rdata_vld_p1;

  logic wr_cfg1, wr_cfg2, wr_ctrl, wr_status, wr_cnt, rd_data;
  logic flush, empty, full, conv_edge, capture;
  logic pop, push, overflow_set, underflow_set;
  logic [15:0] status, rd_mux;

  assign wr_cfg1   = bus.reg_wr_en && (bus.reg_addr == 3'd0);
  assign wr_cfg2   = bus.reg_wr_en && (bus.reg_addr == 3'd1);
  assign wr_ctrl   = bus.reg_wr_en && (bus.reg_addr == 3'd2);
  assign wr_status = bus.reg_wr_en && (bus.reg_addr == 3'd3);
  assign wr_cnt    = bus.reg_wr_en && (bus.reg_addr == 3'd5);
  assign rd_data   = bus.reg_rd_en && (bus.reg_addr == 3'd4);
  assign flush     = wr_ctrl && bus.reg_wdata[1];

  assign empty = (level == '0);
  assign full  = (level == LVL_W'(FIFO_DEPTH));

  // The edge detector always tracks the strobe; only the capture is gated by
  // the ADC enable, so re-enabling while the strobe is high does not push.
  assign conv_edge = conv_finished_in && !conv_prev;
  assign capture   = conv_edge && adc_rst_n_out;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the
  // push. A flush discards any push arriving in its own cycle.
  assign pop           = rd_data && !empty;
  assign underflow_set = rd_data && empty;
  assign push          = capture && (!full || pop) && !flush;
  assign overflow_set  = capture && full && !pop && !flush;

  assign status = {4'b0000, empty, full, underflow, overflow, 1'b0, 7'(level)};

  always_comb begin
    rd_mux = '0;
    case (bus.reg_addr)
      3'd0:    rd_mux = cfg1;
      3'd1:    rd_mux = cfg2;
      3'd2:    rd_mux = {15'd0, ctrl_en};
      3'd3:    rd_mux = status;
      3'd4:    rd_mux = empty ? 16'h0000 : mem[rd_ptr];
      3'd5:    rd_mux = cnt;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg1         <= CFG1_RESET;
      cfg2         <= CFG2_RESET;
      ctrl_en      <= 1'b0;
      conv_prev    <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      cnt          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      rdata_p1     <= '0;
      rdata_vld_p1 <= 1'b0;
    end else begin
      conv_prev <= conv_finished_in;
      if (wr_cfg1) cfg1    <= bus.reg_wdata;
      if (wr_cfg2) cfg2    <= bus.reg_wdata;
      if (wr_ctrl) ctrl_en <= bus.reg_wdata[0];

      // Write-one-to-clear; a set event in the same cycle wins.
      overflow  <= overflow_set  || (overflow  && !(wr_status && bus.reg_wdata[8]));
      underflow <= underflow_set || (underflow && !(wr_status && bus.reg_wdata[9]));

      // CNT counts captured edges, including samples dropped on overflow.
      if (wr_cnt)       cnt <= '0;
      else if (capture) cnt <= cnt + 16'd1;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      level <= level + LVL_W'(1);
        else if (pop && !push) level <= level - LVL_W'(1);
      end

      // Read stage: data is the pre-write value; held until the next read.
      rdata_vld_p1 <= bus.reg_rd_en;
      if (bus.reg_rd_en) rdata_p1 <= rd_mux;
    end
  end

  // Sample storage needs no reset; emptiness is tracked by level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result_in;
  end

  assign config_1_out        = cfg1;
  assign config_2_out        = cfg2;
  assign adc_rst_n_out       = ctrl_en;
  assign fifo_nempty_out     = !empty;
  assign bus.reg_rdata       = rdata_p1;
  assign bus.reg_rdata_valid = rdata_vld_p1;
endmodule

// File: tb/tb_adc_result_reader.sv
// Self-checking bench for adc_result_reader: table-driven register vectors,
// hand-written multi-cycle sequences, and a randomized phase compared each
// cycle against a queue-based reference model.
module tb_adc_result_reader;
  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic [15:0] config_1_out, config_2_out;
  logic        adc_rst_n_out;
  logic [15:0] result_in;
  logic        conv_finished_in;
  logic        fifo_nempty_out;

  adc_result_reader_if bus();

  adc_result_reader #(
    .FIFO_DEPTH(DEPTH),
    .CFG1_RESET(16'h0000),
    .CFG2_RESET(16'h0000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .config_1_out     (config_1_out),
    .config_2_out     (config_2_out),
    .adc_rst_n_out    (adc_rst_n_out),
    .result_in        (result_in),
    .conv_finished_in (conv_finished_in),
    .fifo_nempty_out  (fifo_nempty_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] q[$];
  logic [15:0] m_cfg1, m_cfg2, m_cnt, m_rdata;
  bit          m_en, m_ovf, m_unf, m_prev, m_valid;

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cfg1 = 16'h0000; m_cfg2 = 16'h0000; m_cnt = 16'h0000; m_rdata = 16'h0000;
    m_en = 0; m_ovf = 0; m_unf = 0; m_prev = 0; m_valid = 0;
  endtask

  function automatic logic [15:0] model_status();
    int lvl;
    lvl = q.size();
    return 16'(lvl) | (m_ovf ? 16'h0100 : 16'h0) | (m_unf ? 16'h0200 : 16'h0) |
           ((lvl == DEPTH) ? 16'h0400 : 16'h0) | ((lvl == 0) ? 16'h0800 : 16'h0);
  endfunction

  // One clock of the specified behaviour, from the inputs currently applied.
  task automatic model_step();
    bit wr, rd, cap, flush, pop, uset, oset;
    logic [2:0] a;
    logic [15:0] w, rv;
    if (rst) begin
      model_reset();
      return;
    end
    wr = bus.reg_wr_en; rd = bus.reg_rd_en; a = bus.reg_addr; w = bus.reg_wdata;
    cap = conv_finished_in && !m_prev && m_en;
    m_prev = conv_finished_in;
    flush = wr && a == 3'd2 && w[1];
    rv = 16'h0000;
    case (a)
      3'd0: rv = m_cfg1;
      3'd1: rv = m_cfg2;
      3'd2: rv = {15'd0, m_en};
      3'd3: rv = model_status();
      3'd4: rv = (q.size() != 0) ? q[0] : 16'h0000;
      3'd5: rv = m_cnt;
      default: rv = 16'h0000;
    endcase
    if (rd) m_rdata = rv;
    m_valid = rd;
    pop  = rd && a == 3'd4 && q.size() != 0;
    uset = rd && a == 3'd4 && q.size() == 0;
    oset = 0;
    if (pop) void'(q.pop_front());
    if (flush) q.delete();
    else if (cap) begin
      if (q.size() < DEPTH) q.push_back(result_in);
      else oset = 1;
    end
    if (cap) m_cnt = m_cnt + 16'd1;
    if (wr) begin
      case (a)
        3'd0: m_cfg1 = w;
        3'd1: m_cfg2 = w;
        3'd2: m_en = w[0];
        3'd5: m_cnt = 16'h0000;
        default: ;
      endcase
    end
    m_ovf = oset || (m_ovf && !(wr && a == 3'd3 && w[8]));
    m_unf = uset || (m_unf && !(wr && a == 3'd3 && w[9]));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.reg_wr_en = 0; bus.reg_rd_en = 0; bus.reg_addr = 3'd0; bus.reg_wdata = 16'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    conv_finished_in = 0;
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
    bus.reg_wr_en = 1; bus.reg_addr = a; bus.reg_wdata = d;
    cycle();
    idle_inputs();
  endtask

  task automatic reg_read_check(input string name, input logic [2:0] a, input logic [15:0] exp);
    bus.reg_rd_en = 1; bus.reg_addr = a;
    cycle();
    idle_inputs();
    check({name, "_valid"}, 32'(bus.reg_rdata_valid), 32'd1);
    check(name, 32'(bus.reg_rdata), 32'(exp));
  endtask

  task automatic pulse(input logic [15:0] v);
    result_in = v; conv_finished_in = 1;
    cycle();
    conv_finished_in = 0; result_in = 16'($urandom);
    cycle();
  endtask

  initial begin
    rst = 1;
    result_in = 16'h0;
    conv_finished_in = 0;
    idle_inputs();
    model_reset();

    // Reset values and register map
    vecs[0]  = '{0, 3'd0, 16'h0, 16'h0000};
    vecs[1]  = '{0, 3'd1, 16'h0, 16'h0000};
    vecs[2]  = '{0, 3'd2, 16'h0, 16'h0000};
    vecs[3]  = '{0, 3'd3, 16'h0, 16'h0800};
    vecs[4]  = '{0, 3'd4, 16'h0, 16'h0000};
    vecs[5]  = '{0, 3'd5, 16'h0, 16'h0000};
    vecs[6]  = '{0, 3'd6, 16'h0, 16'h0000};
    vecs[7]  = '{0, 3'd7, 16'h0, 16'h0000};
    vecs[8]  = '{0, 3'd3, 16'h0, 16'h0A00};
    vecs[9]  = '{1, 3'd6, 16'hFFFF, 16'h0};
    vecs[10] = '{0, 3'd6, 16'h0, 16'h0000};
    vecs[11] = '{1, 3'd3, 16'h0200, 16'h0};
    vecs[12] = '{0, 3'd3, 16'h0, 16'h0800};

    do_reset();
    check("rst_valid", 32'(bus.reg_rdata_valid), 32'd0);
    check("rst_rdata", 32'(bus.reg_rdata), 32'd0);
    check("rst_adc_rst_n", 32'(adc_rst_n_out), 32'd0);
    check("rst_nempty", 32'(fifo_nempty_out), 32'd0);
    check("rst_cfg1", 32'(config_1_out), 32'd0);
    check("rst_cfg2", 32'(config_2_out), 32'd0);
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) reg_write(vecs[i].addr, vecs[i].data);
      else reg_read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // Three captures read back in order
    do_reset();
    reg_write(3'd2, 16'h0001);
    check("en_adc_rst_n", 32'(adc_rst_n_out), 32'd1);
    pulse(16'h0101); pulse(16'h0202); pulse(16'h0303);
    check("t2_nempty", 32'(fifo_nempty_out), 32'd1);
    reg_read_check("t2_d0", 3'd4, 16'h0101);
    reg_read_check("t2_d1", 3'd4, 16'h0202);
    reg_read_check("t2_d2", 3'd4, 16'h0303);
    reg_read_check("t2_cnt", 3'd5, 16'h0003);
    reg_read_check("t2_status", 3'd3, 16'h0800);
    check("t2_nempty_end", 32'(fifo_nempty_out), 32'd0);

    // Held strobe pushes once
    result_in = 16'hBEEF; conv_finished_in = 1;
    for (int i = 0; i < 5; i++) cycle();
    conv_finished_in = 0;
    cycle();
    reg_read_check("t3_status", 3'd3, 16'h0001);
    reg_read_check("t3_data", 3'd4, 16'hBEEF);

    // Overflow on the ninth sample, then W1C
    for (int i = 0; i < 9; i++) pulse(16'h1000 + 16'(i));
    reg_read_check("t4_status", 3'd3, 16'h0508);
    reg_write(3'd3, 16'h0100);
    reg_read_check("t4_w1c", 3'd3, 16'h0408);

    // Pop and push together on a full FIFO
    bus.reg_rd_en = 1; bus.reg_addr = 3'd4;
    result_in = 16'h5555; conv_finished_in = 1;
    cycle();
    idle_inputs();
    conv_finished_in = 0;
    check("t5_head", 32'(bus.reg_rdata), 32'h1000);
    cycle();
    reg_read_check("t5_status", 3'd3, 16'h0408);
    for (int i = 1; i < 8; i++) reg_read_check($sformatf("t5_d%0d", i), 3'd4, 16'h1000 + 16'(i));
    reg_read_check("t5_newest", 3'd4, 16'h5555);
    reg_read_check("t5_cnt", 3'd5, 16'h000E);
    reg_write(3'd5, 16'h1234);
    reg_read_check("t5_cnt_clr", 3'd5, 16'h0000);

    // Simultaneous write and read returns the old value; read data holds
    bus.reg_wr_en = 1; bus.reg_rd_en = 1; bus.reg_addr = 3'd0; bus.reg_wdata = 16'hABCD;
    cycle();
    idle_inputs();
    check("wr_rd_old", 32'(bus.reg_rdata), 32'h0000);
    check("wr_rd_cfg1", 32'(config_1_out), 32'hABCD);
    reg_read_check("cfg1_new", 3'd0, 16'hABCD);
    cycle();
    check("hold_rdata", 32'(bus.reg_rdata), 32'hABCD);
    check("hold_valid", 32'(bus.reg_rdata_valid), 32'd0);

    // Disabled ADC ignores strobes; flush drops contents and a same-cycle push
    reg_write(3'd2, 16'h0000);
    check("t6_adc_off", 32'(adc_rst_n_out), 32'd0);
    pulse(16'h0A0A); pulse(16'h0B0B);
    reg_read_check("t6_status_off", 3'd3, 16'h0800);
    reg_read_check("t6_cnt_off", 3'd5, 16'h0000);
    reg_write(3'd2, 16'h0001);
    for (int i = 0; i < 4; i++) pulse(16'h2000 + 16'(i));
    reg_read_check("t6_level4", 3'd3, 16'h0004);
    bus.reg_wr_en = 1; bus.reg_addr = 3'd2; bus.reg_wdata = 16'h0003;
    result_in = 16'h7777; conv_finished_in = 1;
    cycle();
    idle_inputs();
    check("t6_flush_nempty", 32'(fifo_nempty_out), 32'd0);
    conv_finished_in = 0;
    reg_read_check("t6_flush_status", 3'd3, 16'h0800);
    reg_read_check("t6_ctrl", 3'd2, 16'h0001);

    // Reset in the middle of operation
    pulse(16'h3333);
    reg_read_check("mid_pre", 3'd3, 16'h0001);
    rst = 1;
    cycle();
    rst = 0;
    check("mid_adc_rst_n", 32'(adc_rst_n_out), 32'd0);
    check("mid_nempty", 32'(fifo_nempty_out), 32'd0);
    check("mid_valid", 32'(bus.reg_rdata_valid), 32'd0);
    check("mid_rdata", 32'(bus.reg_rdata), 32'd0);
    check("mid_cfg1", 32'(config_1_out), 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    reg_write(3'd2, 16'h0001);
    for (int i = 0; i < 600; i++) begin
      bus.reg_wr_en = ($urandom_range(0, 9) == 0);
      bus.reg_rd_en = ($urandom_range(0, 2) == 0);
      bus.reg_addr  = 3'($urandom_range(0, 7));
      if (bus.reg_rd_en && !bus.reg_wr_en && $urandom_range(0, 1) == 1) bus.reg_addr = 3'd4;
      bus.reg_wdata = 16'($urandom);
      if (bus.reg_wr_en && bus.reg_addr == 3'd2)
        bus.reg_wdata = {14'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0)};
      conv_finished_in = ($urandom_range(0, 2) == 0);
      result_in = 16'($urandom);
      cycle();
      check("rnd_valid", 32'(bus.reg_rdata_valid), 32'(m_valid));
      check("rnd_rdata", 32'(bus.reg_rdata), 32'(m_rdata));
      check("rnd_nempty", 32'(fifo_nempty_out), 32'(q.size() != 0));
      check("rnd_adc_rst_n", 32'(adc_rst_n_out), 32'(m_en));
      check("rnd_cfg1", 32'(config_1_out), 32'(m_cfg1));
      check("rnd_cfg2", 32'(config_2_out), 32'(m_cfg2));
    end
    idle_inputs();
    conv_finished_in = 0;
    cycle();
    reg_read_check("rnd_status_end", 3'd3, model_status());
    reg_read_check("rnd_cnt_end", 3'd5, m_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
